mul_pipe: RTL and testbench
===========================

# mul_pipe

Parametrised multi-lane integer multiplier execution unit. It sits behind register read, alongside the other functional units. It accepts up to `iwd` MUL-class requests per cycle into an in-order buffer and dispatches up to `nlane` per cycle into independent pipelines of `lat` stages. Each lane's result appears on its own `resp` port with per-lane claim back-pressure. It supports RV64 `mul`, `mulh`, `mulhsu`, `mulhu` and `mulw`, and squashes wrong-path work on redirect at every stage.

## Interface
Parameters:
- `iwd`, 4, issue width: request ports per cycle.
- `ewd`, 4, execution width: response ports; requires `nlane <= ewd`.
- `opsz`, 64, operation-ID space; a power of two.
- `nlane`, 2, number of multiplier lanes; 1..`ewd`.
- `lat`, 3, pipeline stages per lane; >= 1.
- `eqsz`, 8, buffer entries; a power of two, >= `iwd`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous reset, active-low.
- `redir`, in, `red_bundle_t`: redirect; valid when `opid[15]`.
- `ready`, out, 1: buffer can take `iwd` requests this cycle.
- `req`, in, `reg_bundle_t [iwd]`: requests after register read.
- `claim`, in, `[ewd]`: `claim[l]` means the consumer takes `resp[l]` this cycle.
- `resp`, out, `exe_bundle_t [ewd]`: results; `resp[l]` for `l < nlane` is driven by lane `l`, the rest are tied 0.

## Operation
- **Request select:** `req[i]` is a MUL request iff `opid[15] & fu[3]`. Selected requests are packed in port order.
- **Enqueue:** packed requests are written at `front+num`, `front+num+1`, … modulo `eqsz`.
- **Same-cycle squash on enqueue:** a request that `younger(opid, redir)` flags in the same cycle is dropped before it is written. Only the surviving ones count in `num`.
- **Ready:** `ready = (eqsz - num) >= iwd`. Upstream never presents MUL requests while `ready` is 0.
- **`younger` function:** with `n = log2(opsz)`, `younger(op, rd)` is `op[15] & rd.opid[15] & ((op - rd.topid) mod 2^n >= (rd.opid - rd.topid) mod 2^n + 1)`.
- **Buffer squash:** a buffered entry that `younger` flags becomes a bubble. A bubble still occupies its slot and is dispatched with `opid = 0`.
- **Lane advance:** lane `l` advances when `claim[l] | ~stage0[l].opid[15]`. Stage 0 is the output stage.
- **Dispatch:** the first `k` buffer entries go, in order, to the first `k` advancing lanes in ascending lane index. `k = min(num, number of advancing lanes)`. `front += k` and `num -= k`.
- **Non-receiving lanes:** an advancing lane that gets no entry shifts in a zero bundle.
- **Pipeline squash:** every stage whose next-state opid is flagged by `younger` is written with `opid = 0`. This includes the stage being dispatched into.
- **Arithmetic:** operands are extended to 128 bits.
  - `a` is sign-extended for `mul`, `mulw`, `mulh`, `mulhsu`.
  - `b` is sign-extended for `mul`, `mulw`, `mulh`.
  - `r = a*b`.
  - `mulw`: `prdv = sext(r[31:0])`.
  - `mulh*`: `prdv = r[127:64]`.
  - Otherwise: `prdv = r[63:0]`.
- **Other result fields:**
  - `opid`, `brid`, `ldid`, `stid`, `delta`, `pc` are copied from the request.
  - `npc = base[63:0] + delta`.
  - `prda = prda[1]`.
- **Ordering:** results from different lanes may complete out of program order. Within one lane, order is preserved.

## Timing
- **Reset** (`rst` low, asynchronous; takes effect immediately):
  - `num = 0`, `front = 0`.
  - All stage and bubble bits 0.
  - `resp` all 0, `ready = 1`.
- **Latency:** a request accepted in cycle 0 is at the buffer head in cycle 1. It is dispatched at the end of cycle 1 and is valid on `resp[l]` in cycle `1+lat`, with no stalls.
- **Throughput:** `nlane` results per cycle sustained.
- **Stall:** an unclaimed valid `resp[l]` freezes all of lane `l`. It holds stable until claimed. Squash still applies during a freeze and can drop the output to `opid = 0`.
- **Wrap-around:** `front` and write addresses wrap modulo `eqsz`. `num` is `log2(eqsz)+1` bits and reaches `eqsz` exactly when full.
- **Simultaneous enqueue and dispatch** in one cycle: `num_next = num + in - k`.
- **Simultaneous redirect and claim:** the claim consumes `resp` as presented. The squash applies to the next state only.
- **Reset asserted mid-operation:** all in-flight work is discarded with no response.

## Structure
- **Shared package `types`:**
  - add `younger()`;
  - reuse the existing `mul_funct_t`, `reg_bundle_t`, `exe_bundle_t`, `red_bundle_t`;
  - add `MUL_LAT_DEFAULT` = 3.
- **Sub-module `mul_lane`** (params `lat`, `opsz`):
  - operand extension, product, result packing;
  - `lat`-stage shift pipeline with advance/squash;
  - inputs: dispatch bundle, valid, `claim`, `redir`;
  - output: stage 0.
- **Top level:** request packing, buffer (flops, async clear), dispatch crossbar, `ready`.

## Test plan
- **Single op:** `nlane=2`, `lat=3`; one `mul` with `prs0 = -3`, `prs1 = 5`, `opid = 0x8004` in cycle 0 → `resp[0].prdv = 0xFFFF_FFFF_FFFF_FFF1` valid in cycle 4, `resp[1]` 0.
- **Function coverage:** `mulhu 0xFFFF_FFFF_FFFF_FFFF * 2` → `1`; `mulhsu -1 * 2` → `0xFFFF_FFFF_FFFF_FFFF`; `mulw 0x7FFF_FFFF * 2` → `0xFFFF_FFFF_FFFF_FFFE`.
- **Back-pressure:**
  - 8 requests over 2 cycles with `claim[0]` held low;
  - lane 0 freezes and lane 1 keeps draining;
  - `ready` drops once `eqsz - num < iwd`;
  - all 8 results appear exactly once after claims resume.
- **Redirect:**
  - ops `opid` 0x8005..0x8008 in flight, `redir.opid = 0x8006`, `redir.topid = 0x8000`;
  - opids 7 and 8 never appear; 5 and 6 complete;
  - a same-cycle request with opid 0x8009 is dropped and does not change `num`.
- **Wrap and reset:**
  - stream 3×`eqsz` ops with random claims → every result correct, no loss or duplication;
  - pull `rst` low mid-stream → `resp` goes to 0 and `ready` to 1 without waiting for a `clk` edge.

Source files
------------

// File: rtl/mul_pipe_pkg.sv
// types: shared bundle types, multiplier defaults and the redirect age compare
package types;
  localparam int MUL_LAT_DEFAULT = 3;
  typedef enum logic [2:0] {MF_MUL, MF_MULH, MF_MULHSU, MF_MULHU, MF_MULW} mul_funct_t;
  typedef struct packed {
    logic [15:0]     opid;
    logic [3:0]      fu;
    mul_funct_t      funct;
    logic [3:0]      brid;
    logic [3:0]      ldid;
    logic [3:0]      stid;
    logic [7:0]      delta;
    logic [63:0]     pc;
    logic [63:0]     base;
    logic [63:0]     prs0;
    logic [63:0]     prs1;
    logic [1:0][6:0] prda;
  } reg_bundle_t;
  typedef struct packed {
    logic [15:0] opid;
    logic [3:0]  brid;
    logic [3:0]  ldid;
    logic [3:0]  stid;
    logic [7:0]  delta;
    logic [63:0] pc;
    logic [63:0] npc;
    logic [6:0]  prda;
    logic [63:0] prdv;
  } exe_bundle_t;
  typedef struct packed {
    logic [15:0] opid;
    logic [15:0] topid;
  } red_bundle_t;
  function automatic logic younger(input logic [15:0] op, input red_bundle_t rd, input int n);
    logic [15:0] m;
    m = 16'((32'd1 << n) - 32'd1);
    return op[15] & rd.opid[15] & ({1'b0, (op - rd.topid) & m} >= {1'b0, (rd.opid - rd.topid) & m} + 17'd1);
  endfunction
endpackage

// File: rtl/mul_pipe_lane.sv
// mul_lane: one multiplier lane with result packing and a stallable, squashable shift pipeline
module mul_lane
  import types::*;
#(
  parameter int lat  = MUL_LAT_DEFAULT,
  parameter int opsz = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  reg_bundle_t din,
  input  logic        dv,
  input  logic        claim,
  input  red_bundle_t redir,
  output exe_bundle_t dout
);
  localparam int n = $clog2(opsz);
  logic sa, sb, adv, unused_bits;
  logic [127:0] a, b, r;
  exe_bundle_t res;
  exe_bundle_t st [lat];
  exe_bundle_t nx [lat];
  function automatic exe_bundle_t sq(input exe_bundle_t x);
    sq = x;
    if (younger(x.opid, redir, n)) sq.opid = '0;
  endfunction
  // extend operands, multiply and pack the result bundle
  always_comb begin
    sa = din.funct != MF_MULHU;
    sb = din.funct inside {MF_MUL, MF_MULW, MF_MULH};
    a = {{64{sa & din.prs0[63]}}, din.prs0};
    b = {{64{sb & din.prs1[63]}}, din.prs1};
    r = a * b;
    res.opid = din.opid;
    res.brid = din.brid;
    res.ldid = din.ldid;
    res.stid = din.stid;
    res.delta = din.delta;
    res.pc = din.pc;
    res.npc = din.base + 64'(din.delta);
    res.prda = din.prda[1];
    res.prdv = din.funct == MF_MULW ? {{32{r[31]}}, r[31:0]} :
               din.funct inside {MF_MULH, MF_MULHSU, MF_MULHU} ? r[127:64] : r[63:0];
  end
  assign unused_bits = ^{din.fu, din.prda[0]};
  assign adv = claim | ~st[0].opid[15];
  for (genvar g = 0; g < lat; g++) begin : g_nx
    if (g == lat - 1) begin : g_in
      assign nx[g] = dv ? res : '0;
    end else begin : g_sh
      assign nx[g] = st[g+1];
    end
  end
  // shift on advance, hold on stall, squash wrong-path ops in whatever gets written
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < lat; i++) st[i] <= '0;
    else for (int i = 0; i < lat; i++) st[i] <= sq(adv ? nx[i] : st[i]);
  assign dout = st[0];
endmodule

// File: rtl/mul_pipe.sv
// mul_pipe: multi-lane multiplier unit with in-order request buffer and per-lane dispatch
module mul_pipe
  import types::*;
#(
  parameter int iwd   = 4,
  parameter int ewd   = 4,
  parameter int opsz  = 64,
  parameter int nlane = 2,
  parameter int lat   = MUL_LAT_DEFAULT,
  parameter int eqsz  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  red_bundle_t     redir,
  output logic            ready,
  input  reg_bundle_t     req [iwd],
  input  logic [ewd-1:0]  claim,
  output exe_bundle_t     resp [ewd]
);
  localparam int aw = $clog2(eqsz);
  localparam int n = $clog2(opsz);
  reg_bundle_t q [eqsz];
  logic [aw-1:0] front;
  logic [aw:0] num, cnt, k;
  logic [aw-1:0] wa [iwd];
  logic [iwd-1:0] we;
  logic [nlane-1:0] adv, dv;
  reg_bundle_t din [nlane];
  exe_bundle_t lo [nlane];
  logic unused_claim;
  // pack surviving MUL requests into write slots and hand head entries to advancing lanes
  always_comb begin
    cnt = '0;
    for (int i = 0; i < iwd; i++) begin
      we[i] = req[i].opid[15] & req[i].fu[3] & ~younger(req[i].opid, redir, n);
      wa[i] = front + num[aw-1:0] + cnt[aw-1:0];
      cnt = cnt + (aw+1)'(we[i]);
    end
    k = '0;
    for (int l = 0; l < nlane; l++) begin
      adv[l] = claim[l] | ~lo[l].opid[15];
      dv[l] = adv[l] & (k < num);
      din[l] = q[front + k[aw-1:0]];
      k = k + (aw+1)'(dv[l]);
    end
  end
  // buffer bookkeeping; squashed entries stay as bubbles so ordering of slots is unchanged
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      front <= '0;
      num <= '0;
      for (int e = 0; e < eqsz; e++) q[e] <= '0;
    end else begin
      front <= front + k[aw-1:0];
      num <= num + cnt - k;
      for (int e = 0; e < eqsz; e++) if (younger(q[e].opid, redir, n)) q[e].opid <= '0;
      for (int i = 0; i < iwd; i++) if (we[i]) q[wa[i]] <= req[i];
    end
  assign ready = eqsz - int'(num) >= iwd;
  assign unused_claim = ^claim;
  for (genvar g = 0; g < ewd; g++) begin : g_ln
    if (g < nlane) begin : g_on
      mul_lane #(.lat(lat), .opsz(opsz)) u_lane (
        .clk(clk), .rst(rst), .din(din[g]), .dv(dv[g]), .claim(claim[g]), .redir(redir), .dout(lo[g])
      );
      assign resp[g] = lo[g];
    end else begin : g_off
      assign resp[g] = '0;
    end
  end
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed scenario checks for mul_pipe
module tb_mul_pipe;
  import types::*;
  logic clk = 0, rst = 0, ready;
  red_bundle_t redir = '0;
  reg_bundle_t req [4];
  logic [3:0] claim = '0;
  exe_bundle_t resp [4];
  int n_cmp = 0, n_bad = 0, got_tot = 0;
  int got_cnt [256];
  logic [63:0] got_val [256];
  mul_pipe dut (.clk(clk), .rst(rst), .redir(redir), .ready(ready), .req(req), .claim(claim), .resp(resp));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst)
      for (int l = 0; l < 4; l++)
        if (resp[l].opid[15] && claim[l]) begin
          got_cnt[resp[l].opid[7:0]]++;
          got_val[resp[l].opid[7:0]] = resp[l].prdv;
          got_tot++;
        end
  function automatic reg_bundle_t mk(input logic [15:0] id, input mul_funct_t f, input logic [63:0] a, input logic [63:0] b);
    mk = '0;
    mk.opid = id;
    mk.fu = 4'b1000;
    mk.funct = f;
    mk.prs0 = a;
    mk.prs1 = b;
    mk.pc = 64'h1000;
    mk.base = 64'h2000;
    mk.delta = 8'd4;
    mk.prda[1] = 7'd9;
    mk.prda[0] = 7'd3;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_req();
    for (int p = 0; p < 4; p++) req[p] = '0;
  endtask
  task automatic clr_got();
    for (int i = 0; i < 256; i++) begin
      got_cnt[i] = 0;
      got_val[i] = '0;
    end
    got_tot = 0;
  endtask
  task automatic test_reset();
    clr_req();
    #12;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    for (int l = 0; l < 4; l++) begin
      n_cmp++; if (resp[l] !== '0) begin n_bad++; $display("FAIL reset_resp%0d: got opid %h want all zero", l, resp[l].opid); end
    end
    @(posedge clk);
    #1 rst = 1;
  endtask
  task automatic test_single();
    reg_bundle_t alu;
    clr_got();
    claim = 4'hF;
    alu = mk(16'h8003, MF_MUL, 64'd1, 64'd1);
    alu.fu = 4'b0001;
    req[0] = mk(16'h8004, MF_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    req[1] = alu;
    step();
    clr_req();
    step();
    step();
    n_cmp++; if (resp[0].opid !== 16'h0) begin n_bad++; $display("FAIL single_early: got opid %h want 0000 in cycle 3", resp[0].opid); end
    step();
    n_cmp++; if (resp[0].opid !== 16'h8004) begin n_bad++; $display("FAIL single_opid: got %h want 8004 in cycle 4", resp[0].opid); end
    n_cmp++; if (resp[0].prdv !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_bad++; $display("FAIL single_prdv: got %h want fffffffffffffff1", resp[0].prdv); end
    n_cmp++; if (resp[0].npc !== 64'h2004) begin n_bad++; $display("FAIL single_npc: got %h want 2004", resp[0].npc); end
    n_cmp++; if (resp[0].pc !== 64'h1000 || resp[0].prda !== 7'd9) begin n_bad++; $display("FAIL single_fields: got pc %h prda %0d want 1000 / 9", resp[0].pc, resp[0].prda); end
    for (int l = 1; l < 4; l++) begin
      n_cmp++; if (resp[l] !== '0) begin n_bad++; $display("FAIL single_resp%0d: got opid %h want all zero", l, resp[l].opid); end
    end
    step();
    n_cmp++; if (resp[0].opid !== 16'h0) begin n_bad++; $display("FAIL single_once: got opid %h want 0000 after claim", resp[0].opid); end
    repeat (6) step();
    n_cmp++; if (got_cnt[8'h03] !== 0) begin n_bad++; $display("FAIL single_nonmul: got %0d results for non-MUL request want 0", got_cnt[8'h03]); end
  endtask
  task automatic test_funct();
    logic [63:0] exp_v [3];
    exp_v[0] = 64'h1;
    exp_v[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_v[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    clr_got();
    req[0] = mk(16'h8010, MF_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    req[1] = mk(16'h8011, MF_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    req[2] = mk(16'h8012, MF_MULW, 64'h7FFF_FFFF, 64'd2);
    step();
    clr_req();
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (got_cnt[8'h10 + i] !== 1) begin n_bad++; $display("FAIL funct_cnt%0d: got %0d results want 1", i, got_cnt[8'h10 + i]); end
      n_cmp++; if (got_val[8'h10 + i] !== exp_v[i]) begin n_bad++; $display("FAIL funct_val%0d: got %h want %h", i, got_val[8'h10 + i], exp_v[i]); end
    end
  endtask
  task automatic test_back_to_back();
    clr_got();
    claim = 4'b1110;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready0: got %b want 1", ready); end
    for (int p = 0; p < 4; p++) req[p] = mk(16'h8020 + 16'(p), MF_MUL, 64'(32 + p), 64'd3);
    step();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready1: got %b want 1", ready); end
    for (int p = 0; p < 4; p++) req[p] = mk(16'h8024 + 16'(p), MF_MUL, 64'(36 + p), 64'd3);
    step();
    clr_req();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_drop: got %b want 0", ready); end
    repeat (10) step();
    n_cmp++; if (resp[0].opid !== 16'h8020) begin n_bad++; $display("FAIL bp_frozen: got opid %h want 8020", resp[0].opid); end
    step();
    n_cmp++; if (resp[0].opid !== 16'h8020 || resp[0].prdv !== 64'd96) begin n_bad++; $display("FAIL bp_hold: got opid %h prdv %h want 8020 / 60", resp[0].opid, resp[0].prdv); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b want 1", ready); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got_cnt[8'h20 + i] !== ((i % 2 == 1 || i >= 6) ? 1 : 0)) begin
        n_bad++; $display("FAIL bp_drain%0d: got %0d results while lane 0 stalled", i, got_cnt[8'h20 + i]);
      end
    end
    claim = 4'hF;
    repeat (10) step();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got_cnt[8'h20 + i] !== 1 || got_val[8'h20 + i] !== 64'((32 + i) * 3)) begin
        n_bad++; $display("FAIL bp_final%0d: got cnt %0d val %h want 1 / %h", i, got_cnt[8'h20 + i], got_val[8'h20 + i], 64'((32 + i) * 3));
      end
    end
  endtask
  task automatic test_redirect();
    clr_got();
    claim = 4'hF;
    for (int p = 0; p < 4; p++) req[p] = mk(16'h8005 + 16'(p), MF_MUL, 64'(p + 2), 64'd10);
    step();
    clr_req();
    step();
    step();
    redir.opid = 16'h8006;
    redir.topid = 16'h8000;
    req[0] = mk(16'h8009, MF_MUL, 64'd7, 64'd7);
    step();
    redir = '0;
    clr_req();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL redir_ready: got %b want 1", ready); end
    repeat (8) step();
    n_cmp++; if (got_cnt[8'h05] !== 1 || got_val[8'h05] !== 64'd20) begin n_bad++; $display("FAIL redir_op5: got cnt %0d val %h want 1 / 14", got_cnt[8'h05], got_val[8'h05]); end
    n_cmp++; if (got_cnt[8'h06] !== 1 || got_val[8'h06] !== 64'd30) begin n_bad++; $display("FAIL redir_op6: got cnt %0d val %h want 1 / 1e", got_cnt[8'h06], got_val[8'h06]); end
    for (int i = 7; i < 10; i++) begin
      n_cmp++; if (got_cnt[i] !== 0) begin n_bad++; $display("FAIL redir_squash%0d: got %0d results want 0", i, got_cnt[i]); end
    end
  endtask
  task automatic test_wrap();
    int i = 0, t = 0;
    clr_got();
    while (i < 24 && t < 2000) begin
      clr_req();
      claim = 4'($urandom);
      if (ready)
        for (int p = 0; p < 4 && i < 24; p++)
          if ($urandom_range(0, 1) == 1) begin
            req[p] = mk(16'h8030 + 16'(i), MF_MUL, 64'(i + 1), 64'(i + 7));
            i++;
          end
      step();
      t++;
    end
    clr_req();
    while (got_tot < 24 && t < 2000) begin
      claim = 4'($urandom);
      step();
      t++;
    end
    claim = 4'hF;
    repeat (6) step();
    n_cmp++; if (got_tot !== 24) begin n_bad++; $display("FAIL wrap_total: got %0d results want 24 (issued %0d)", got_tot, i); end
    for (int j = 0; j < 24; j++) begin
      n_cmp++;
      if (got_cnt[8'h30 + j] !== 1 || got_val[8'h30 + j] !== 64'(j + 1) * 64'(j + 7)) begin
        n_bad++; $display("FAIL wrap_op%0d: got cnt %0d val %h want 1 / %h", j, got_cnt[8'h30 + j], got_val[8'h30 + j], 64'(j + 1) * 64'(j + 7));
      end
    end
  endtask
  task automatic test_reset_mid();
    int s = 0;
    clr_got();
    claim = 4'h0;
    for (int p = 0; p < 4; p++) req[p] = mk(16'h8050 + 16'(p), MF_MUL, 64'(p), 64'd2);
    step();
    clr_req();
    repeat (6) step();
    for (int p = 0; p < 4; p++) req[p] = mk(16'h8054 + 16'(p), MF_MUL, 64'(p), 64'd2);
    step();
    for (int p = 0; p < 4; p++) req[p] = mk(16'h8058 + 16'(p), MF_MUL, 64'(p), 64'd2);
    step();
    clr_req();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rmid_full: got ready %b want 0", ready); end
    n_cmp++; if (resp[0].opid !== 16'h8050 || resp[1].opid !== 16'h8051) begin n_bad++; $display("FAIL rmid_stalled: got %h %h want 8050 8051", resp[0].opid, resp[1].opid); end
    #3 rst = 0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1 before clock edge", ready); end
    for (int l = 0; l < 4; l++) begin
      n_cmp++; if (resp[l] !== '0) begin n_bad++; $display("FAIL rmid_resp%0d: got opid %h want all zero before clock edge", l, resp[l].opid); end
    end
    @(posedge clk);
    #1 rst = 1;
    claim = 4'hF;
    repeat (12) step();
    for (int j = 0; j < 12; j++) s += got_cnt[8'h50 + j];
    n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL rmid_discard: got %0d responses after reset want 0", s); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_funct();
    test_back_to_back();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
